// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter,
// mode-qualified edge pulse and sticky event flag with per-channel clear.

module multi_edge_detector_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       sticky
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          synced;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          pls_q, pls_d;
  logic          stk_q, stk_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // shift the raw input through the synchroniser chain
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= (sync_q << 1) | SYNC_STAGES'(in);
      end
      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // debounce: count consecutive disagreements, toggle when the run completes
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    pls_d = 1'b0;
    if (synced != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        lvl_d = ~lvl_q;
        // mode[0] qualifies 0->1 toggles, mode[1] qualifies 1->0 toggles
        pls_d = lvl_q ? mode[1] : mode[0];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // a new event wins over a same-cycle clear
    stk_d = pls_d | (stk_q & ~clr);
  end

  // channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
      pls_q <= 1'b0;
      stk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      pls_q <= pls_d;
      stk_q <= stk_d;
    end
  end

  assign level  = lvl_q;
  assign pulse  = pls_q;
  assign sticky = stk_q;
endmodule

module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   sticky,
  output logic               any_pulse,
  output logic               irq
);
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      multi_edge_detector_lane #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE   (DEBOUNCE)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .in    (in[i]),
        .mode  (mode[2*i +: 2]),
        .clr   (clr[i]),
        .level (level[i]),
        .pulse (pulse[i]),
        .sticky(sticky[i])
      );
    end
  endgenerate

  assign any_pulse = |pulse;
  assign irq       = |sticky;
endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter WIDTH, default 8: number of independent channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel (0..3); 0 means no synchroniser.
REQ-003 Parameter DEBOUNCE, default 4: consecutive disagreeing cycles required before the filtered level changes (1..255).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in  input  WIDTH  raw channel inputs, possibly asynchronous to clk.
REQ-007 mode  input  2*WIDTH  per-channel mode; bits [2i+1:2i] for channel i: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 clr  input  WIDTH  per-channel sticky-clear strobe.
REQ-009 level  output  WIDTH  registered, debounced channel level.
REQ-010 pulse  output  WIDTH  registered one-cycle edge pulse per channel.
REQ-011 sticky  output  WIDTH  registered latched-event flags.
REQ-012 any_pulse  output  1  OR of pulse.
REQ-013 irq  output  1  OR of sticky.

Function
REQ-014 Each channel SHALL pass in[i] through SYNC_STAGES flops; the last stage output is "synced". With SYNC_STAGES=0, synced is in[i] directly.
REQ-015 Each channel SHALL have a debounce counter of ceil(log2(DEBOUNCE+1)) bits.
- Counter clears on any edge where synced equals level.
- Counter increments on each edge where synced differs from level.
REQ-016 level[i] SHALL toggle on the edge where synced differs and the counter equals DEBOUNCE-1; the counter clears on that same edge.
REQ-017 A disagreement lasting fewer than DEBOUNCE consecutive edges SHALL leave level unchanged and produce no pulse.
REQ-018 Latency from a stable change on in[i] to the level/pulse update SHALL be exactly SYNC_STAGES+DEBOUNCE rising edges.
REQ-019 pulse[i] SHALL be high for exactly the one cycle following a level toggle, and only if mode permits the edge:
- rise: 0->1 toggles only.
- fall: 1->0 toggles only.
- both: any toggle.
- off: never.
REQ-020 mode SHALL be sampled on the toggle edge only. Changing mode never creates, extends or cancels a pulse. level continues tracking while mode is off.
REQ-021 pulse SHALL never be high on consecutive cycles for one channel; the minimum toggle spacing is DEBOUNCE cycles.
REQ-022 sticky[i] SHALL set on the edge that asserts pulse[i], and clear on an edge with clr[i]=1.
- Set and clear on the same edge: set wins, sticky stays 1.
REQ-023 clr on a channel whose sticky is 0 SHALL have no effect. clr SHALL never affect level, pulse or the counter.
REQ-024 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported in the same cycle.
REQ-025 any_pulse and irq SHALL be combinational ORs of the registered pulse and sticky vectors (no added latency).

Reset
REQ-026 While rst=1 at an edge, the following SHALL be 0 on the next cycle: synchroniser flops, counters, level, pulse, sticky. Consequently any_pulse=0 and irq=0.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for that disagreement.
REQ-028 An input held high through reset release SHALL be treated as a 0->1 transition.
- level rises, and a rise/both pulse fires, SYNC_STAGES+DEBOUNCE edges after the first edge with rst=0.

Verification
REQ-029 Rise latency: defaults, mode0=01, in[0] 0->1 held -> pulse[0]=1 for one cycle exactly 6 edges later; sticky[0]=1 and irq=1 from then on.
REQ-030 Glitch rejection: defaults, in[0] high for 3 cycles then low -> level[0], pulse[0] and sticky[0] remain 0 throughout.
REQ-031 Mode coverage: channels 0..3 with modes 00/01/10/11, square wave of period 20 cycles:
- ch0: no pulses.
- ch1: rising edges only.
- ch2: falling edges only.
- ch3: both edges.
- level toggles identically on all four channels.
REQ-032 Set/clear race: clr[1]=1 asserted on the same edge as a pulse[1] assertion -> sticky[1]=1. clr[1]=1 on the next edge -> sticky[1]=0 and irq=0.
REQ-033 Reset corners:
- rst pulsed at debounce count 2 -> no pulse.
- in held high across reset release -> rise pulse 6 edges after release.
REQ-034 Parameter sweep: SYNC_STAGES=0, DEBOUNCE=1, WIDTH=1 -> pulse appears 1 edge after an in change; randomised in vs. reference model shows 0 mismatches over 10^5 cycles.
